// File: rtl/alu_mem_unit.sv
// Single-cycle datapath slice: instruction and data word memories with
// combinational reads, plus the combinational ALU / next-PC logic.
module alu_mem_unit #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [31:0] inst,
    input  logic        im_we,
    input  logic [15:0] im_addr,
    input  logic [31:0] im_wdata,
    input  logic [15:0] dataAddress,
    input  logic [31:0] dataIn,
    input  logic        mode,
    output logic [31:0] dataOut,
    input  logic [5:0]  opcode,
    input  logic [4:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic [15:0] constant,
    input  logic [25:0] jumpAddress,
    output logic [31:0] dest,
    output logic [15:0] pcNew
);
    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [31:0] imem_reg [IMEM_DEPTH];
    logic [31:0] dmem_reg [DMEM_DEPTH];

    logic [IAW-1:0] pc_idx;
    logic [IAW-1:0] im_wr_idx;
    logic [DAW-1:0] d_idx;

    // Addresses wrap modulo the depth, so non-power-of-two depths alias correctly.
    assign pc_idx    = IAW'(32'(pc) % 32'(IMEM_DEPTH));
    assign im_wr_idx = IAW'(32'(im_addr) % 32'(IMEM_DEPTH));
    assign d_idx     = DAW'(32'(dataAddress) % 32'(DMEM_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                imem_reg[i] <= '0;
            end
        end else if (im_we) begin
            imem_reg[im_wr_idx] <= im_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_reg[i] <= '0;
            end
        end else if (mode) begin
            dmem_reg[d_idx] <= dataIn;
        end
    end

    assign inst    = imem_reg[pc_idx];
    assign dataOut = dmem_reg[d_idx];

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [15:0] branch_target;
    logic        unused_jump_bits;

    assign imm_sext         = {{16{constant[15]}}, constant};
    assign imm_zext         = {16'h0000, constant};
    assign branch_target    = pc + constant;
    assign unused_jump_bits = ^jumpAddress[25:16];

    always_comb begin
        dest  = '0;
        pcNew = pc;
        case (opcode)
            6'd0: begin
                case (funct)
                    5'd0, 5'd2: dest = s1 + s2;
                    5'd1, 5'd3: dest = s1 - s2;
                    5'd4:       dest = s1 & s2;
                    5'd5:       dest = s1 | s2;
                    5'd6:       dest = s2 << shamt;
                    5'd7:       dest = s2 >> shamt;
                    5'd8:       dest = {31'h0, $signed(s1) < $signed(s2)};
                    default:    dest = '0;
                endcase
            end
            6'd1:       dest = s1 + imm_sext;
            6'd2:       dest = s1 + imm_zext;
            6'd3:       dest = s1 & imm_zext;
            6'd4:       dest = s1 | imm_zext;
            6'd5, 6'd6: dest = s1 + imm_sext;
            6'd7:  if (s1 == s2)                   pcNew = branch_target;
            6'd8:  if (s1 != s2)                   pcNew = branch_target;
            6'd9:  if ($signed(s1) >  $signed(s2)) pcNew = branch_target;
            6'd10: if ($signed(s1) >= $signed(s2)) pcNew = branch_target;
            6'd11: if ($signed(s1) <  $signed(s2)) pcNew = branch_target;
            6'd12: if ($signed(s1) <= $signed(s2)) pcNew = branch_target;
            6'd13: pcNew = jumpAddress[15:0];
            6'd14: pcNew = s1[15:0];
            6'd15: begin
                pcNew = jumpAddress[15:0];
                dest  = 32'(pc) + 32'd1;
            end
            6'd16: dest = {31'h0, $signed(s1) < $signed(imm_sext)};
            default: begin
                dest  = '0;
                pcNew = pc;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed and randomized checks of alu_mem_unit against a behavioural model.
module tb_alu_mem_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [31:0] inst;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic [15:0] dataAddress;
    logic [31:0] dataIn;
    logic        mode;
    logic [31:0] dataOut;
    logic [5:0]  opcode;
    logic [4:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [15:0] constant;
    logic [25:0] jumpAddress;
    logic [31:0] dest;
    logic [15:0] pcNew;

    int passed = 0;
    int total  = 0;

    logic [31:0] imem_m [256];
    logic [31:0] dmem_m [256];

    alu_mem_unit #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dataAddress(dataAddress), .dataIn(dataIn), .mode(mode), .dataOut(dataOut),
        .opcode(opcode), .funct(funct), .shamt(shamt), .s1(s1), .s2(s2),
        .constant(constant), .jumpAddress(jumpAddress), .dest(dest), .pcNew(pcNew)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_alu(input logic [5:0] op, input logic [4:0] fn, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] k,
                           input logic [25:0] ja, input logic [15:0] p);
        opcode = op; funct = fn; shamt = sh; s1 = a; s2 = b;
        constant = k; jumpAddress = ja; pc = p;
        #1;
    endtask

    // Reference model: plain signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [5:0] op, input logic [4:0] fn, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b, input logic [15:0] k,
                                  input logic [25:0] ja, input logic [15:0] p,
                                  output logic [31:0] d, output logic [15:0] np);
        int sa, sb, sk;
        bit taken;
        sa = a; sb = b;
        sk = int'(shortint'(k));
        d = 0; np = p; taken = 0;
        case (int'(op))
            0: case (int'(fn))
                0, 2: d = a + b;
                1, 3: d = a - b;
                4: d = a & b;
                5: d = a | b;
                6: d = b << sh;
                7: d = b >> sh;
                8: d = (sa < sb) ? 1 : 0;
                default: d = 0;
            endcase
            1, 5, 6: d = 32'(sa + sk);
            2: d = a + {16'h0, k};
            3: d = a & {16'h0, k};
            4: d = a | {16'h0, k};
            16: d = (sa < sk) ? 1 : 0;
            7:  taken = (sa == sb);
            8:  taken = (sa != sb);
            9:  taken = (sa > sb);
            10: taken = (sa >= sb);
            11: taken = (sa < sb);
            12: taken = (sa <= sb);
            13: np = ja[15:0];
            14: np = a[15:0];
            15: begin np = ja[15:0]; d = 32'(int'(p) + 1); end
            default: ;
        endcase
        if (taken) np = 16'(int'(p) + sk);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            imem_m[i] = 0;
            dmem_m[i] = 0;
        end
    endtask

    initial begin
        logic [31:0] exp_d;
        logic [15:0] exp_pc;
        logic [5:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        w_i, w_d;
        logic [15:0] a_i, a_d;
        logic [31:0] v_i, v_d;

        rst_n = 1'b0; im_we = 0; im_addr = 0; im_wdata = 0;
        dataAddress = 0; dataIn = 0; mode = 0;
        set_alu(0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;

        pc = 16'd5; dataAddress = 16'd5; #1;
        check("reset_inst", inst, 32'h0);
        check("reset_dataOut", dataOut, 32'h0);

        set_alu(0, 0, 0, 32'd7, 32'hFFFFFFFD, 0, 0, 0);
        check("add", dest, 32'd4);
        set_alu(0, 1, 0, 32'd5, 32'd9, 0, 0, 0);
        check("sub", dest, 32'hFFFFFFFC);
        set_alu(0, 6, 4, 32'd0, 32'd1, 0, 0, 0);
        check("sll", dest, 32'd16);
        set_alu(0, 8, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        check("slt", dest, 32'd1);

        @(negedge clk);
        mode = 1; dataAddress = 16'd3; dataIn = 32'hDEADBEEF;
        @(posedge clk); #1;
        mode = 0; dmem_m[3] = 32'hDEADBEEF; #1;
        check("dmem_addr3", dataOut, 32'hDEADBEEF);
        dataAddress = 16'd259; #1;
        check("dmem_alias259", dataOut, 32'hDEADBEEF);

        set_alu(7, 0, 0, 32'd9, 32'd9, 16'hFFFE, 0, 16'd10);
        check("beq_taken", pcNew, 16'd8);
        check("beq_dest", dest, 32'h0);
        set_alu(7, 0, 0, 32'd9, 32'd8, 16'hFFFE, 0, 16'd10);
        check("beq_not_taken", pcNew, 16'd10);
        set_alu(9, 0, 0, 32'd1, 32'hFFFFFFFF, 16'hFFFE, 0, 16'd10);
        check("bgt_signed", pcNew, 16'd8);

        set_alu(15, 0, 0, 0, 0, 0, 26'd40, 16'd5);
        check("jal_pcNew", pcNew, 16'd40);
        check("jal_dest", dest, 32'd6);
        set_alu(14, 0, 0, 32'h00001234, 0, 0, 0, 16'd5);
        check("jr_pcNew", pcNew, 16'h1234);
        check("jr_dest", dest, 32'h0);

        for (int n = 0; n < 300; n++) begin
            r_op = 6'($urandom_range(0, 20));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            set_alu(r_op, 5'($urandom_range(0, 12)), 5'($urandom), r_a, r_b,
                    16'($urandom), 26'($urandom), 16'($urandom_range(0, 16'hFFFE)));
            model(opcode, funct, shamt, s1, s2, constant, jumpAddress, pc, exp_d, exp_pc);
            check($sformatf("rand_dest op=%0d fn=%0d", opcode, funct), dest, exp_d);
            check($sformatf("rand_pcNew op=%0d", opcode), pcNew, exp_pc);
        end

        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            w_i = 1'($urandom); w_d = 1'($urandom);
            a_i = 16'($urandom_range(0, 767)); a_d = 16'($urandom_range(0, 767));
            v_i = $urandom; v_d = $urandom;
            im_we = w_i; im_addr = a_i; im_wdata = v_i;
            mode = w_d; dataAddress = a_d; dataIn = v_d;
            @(posedge clk); #1;
            if (w_i) imem_m[a_i % 256] = v_i;
            if (w_d) dmem_m[a_d % 256] = v_d;
            im_we = 0; mode = 0;
            pc = (n % 2 == 0) ? a_i : 16'($urandom_range(0, 767));
            dataAddress = (n % 3 == 0) ? 16'($urandom_range(0, 767)) : a_d;
            #1;
            check($sformatf("mem_inst pc=%0d", pc), inst, imem_m[pc % 256]);
            check($sformatf("mem_dataOut addr=%0d", dataAddress), dataOut, dmem_m[dataAddress % 256]);
        end

        @(negedge clk);
        im_we = 1; im_addr = 16'd7; im_wdata = 32'h11223344;
        mode = 1; dataAddress = 16'd7; dataIn = 32'h55667788;
        @(posedge clk); #1;
        imem_m[7] = 32'h11223344; dmem_m[7] = 32'h55667788;
        pc = 16'd7; #1;
        check("pre_reset_inst", inst, imem_m[7]);
        check("pre_reset_dataOut", dataOut, dmem_m[7]);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        clear_model();
        check("async_reset_inst", inst, 32'h0);
        check("async_reset_dataOut", dataOut, 32'h0);
        im_wdata = 32'hCAFEF00D; dataIn = 32'hBADC0FFE;
        @(posedge clk); #1;
        rst_n = 1'b1; im_we = 0; mode = 0; #1;
        check("rst_write_inst", inst, imem_m[7]);
        check("rst_write_dataOut", dataOut, dmem_m[7]);
        pc = 16'd135; dataAddress = 16'd3; #1;
        check("rst_clear_inst", inst, 32'h0);
        check("rst_clear_dataOut", dataOut, 32'h0);

        set_alu(15, 0, 0, 0, 0, 0, 26'h3FF0010, 16'h0100);
        check("jal_after_reset_pcNew", pcNew, 16'h0010);
        check("jal_after_reset_dest", dest, 32'h00000101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
